path_traceback: RTL

Downstream stage of the grid shortest-path solver. Once the solver has filled the accumulated-cost memory (L) and the predecessor memory (P), this block walks P backwards from the bottom-right cell to the origin. It writes the direction code of each visited cell into a path memory (Q) and reports the total path cost and path length. It owns the read ports of L and P and the write port of Q while busy.

---
 rtl/path_traceback_if.sv | 37 +++
 rtl/path_traceback.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/path_traceback_if.sv
// Memory and control bundle between path_traceback (master) and the
// surrounding solver / memory side (slave).
interface path_traceback_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 13
);
    logic               go;
    logic [D_WIDTH-1:0] p_in;
    logic [D_WIDTH-1:0] l_in;
    logic [A_WIDTH-1:0] p_addr;
    logic [A_WIDTH-1:0] l_addr;
    logic [A_WIDTH-1:0] q_addr;
    logic               p_en;
    logic               p_rw;
    logic               l_en;
    logic               l_rw;
    logic               q_en;
    logic               q_rw;
    logic [D_WIDTH-1:0] q_out;
    logic [D_WIDTH-1:0] cost;
    logic [A_WIDTH-1:0] len;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  go, p_in, l_in,
        output p_addr, l_addr, q_addr, p_en, p_rw, l_en, l_rw, q_en, q_rw,
               q_out, cost, len, busy, done, err
    );

    modport slave (
        output go, p_in, l_in,
        input  p_addr, l_addr, q_addr, p_en, p_rw, l_en, l_rw, q_en, q_rw,
               q_out, cost, len, busy, done, err
    );
endinterface

// File: rtl/path_traceback.sv
// Walks the predecessor memory from the bottom-right cell back to the origin,
// writing each direction code to Q and reporting path cost and length.
module path_traceback #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 13,
    parameter int COLS    = 4,
    parameter int ROWS    = 2048
) (
    input  logic clk,
    input  logic rst_n,
    path_traceback_if.master bus
);
    localparam logic [D_WIDTH-1:0] CODE_START = D_WIDTH'(8'h08);
    localparam logic [D_WIDTH-1:0] CODE_RIGHT = D_WIDTH'(8'h09);
    localparam logic [D_WIDTH-1:0] CODE_DOWN  = D_WIDTH'(8'h0A);
    localparam logic [A_WIDTH-1:0] LAST_ADDR  = A_WIDTH'(ROWS * COLS - 1);
    localparam logic [A_WIDTH-1:0] LAST_ROW   = A_WIDTH'(ROWS - 1);
    localparam logic [A_WIDTH-1:0] LAST_COL   = A_WIDTH'(COLS - 1);
    localparam logic [A_WIDTH-1:0] ROW_STEP   = A_WIDTH'(COLS);

    typedef enum logic [2:0] {IDLE, RD_L, CAP_L, RD_P, CAP_P, EVAL, DONE} state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] row, row_nxt, col, col_nxt, cur_addr, addr_nxt;
    logic [A_WIDTH-1:0] len, len_nxt, p_addr, p_addr_nxt, l_addr, l_addr_nxt;
    logic [A_WIDTH-1:0] q_addr, q_addr_nxt;
    logic [D_WIDTH-1:0] p_reg, p_reg_nxt, cost, cost_nxt, q_out, q_out_nxt;
    logic               err, err_nxt, p_en, p_en_nxt, l_en, l_en_nxt;
    logic               q_en, q_en_nxt, busy, done;

    function automatic logic step_ok(input logic [D_WIDTH-1:0] code,
                                     input logic [A_WIDTH-1:0] r,
                                     input logic [A_WIDTH-1:0] c);
        step_ok = ((code == CODE_START) && (r == '0) && (c == '0)) ||
                  ((code == CODE_RIGHT) && (c != '0)) ||
                  ((code == CODE_DOWN)  && (r != '0));
    endfunction

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        addr_nxt   = cur_addr;
        len_nxt    = len;
        cost_nxt   = cost;
        err_nxt    = err;
        p_reg_nxt  = p_reg;
        p_addr_nxt = p_addr;
        l_addr_nxt = l_addr;
        q_addr_nxt = q_addr;
        q_out_nxt  = q_out;
        p_en_nxt   = 1'b0;
        l_en_nxt   = 1'b0;
        q_en_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.go) begin
                    len_nxt    = '0;
                    err_nxt    = 1'b0;
                    cost_nxt   = '0;
                    row_nxt    = LAST_ROW;
                    col_nxt    = LAST_COL;
                    addr_nxt   = LAST_ADDR;
                    l_en_nxt   = 1'b1;
                    l_addr_nxt = LAST_ADDR;
                    state_nxt  = RD_L;
                end
            end
            RD_L: state_nxt = CAP_L;
            CAP_L: begin
                cost_nxt   = bus.l_in;
                p_en_nxt   = 1'b1;
                p_addr_nxt = cur_addr;
                state_nxt  = RD_P;
            end
            RD_P: state_nxt = CAP_P;
            CAP_P: begin
                // The Q write is decided here so that it is a registered output during EVAL.
                p_reg_nxt = bus.p_in;
                if (step_ok(bus.p_in, row, col)) begin
                    q_en_nxt   = 1'b1;
                    q_addr_nxt = len;
                    q_out_nxt  = bus.p_in;
                end
                state_nxt = EVAL;
            end
            EVAL: begin
                if (!step_ok(p_reg, row, col)) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    len_nxt = len + 1'b1;
                    if (p_reg == CODE_START) begin
                        state_nxt = DONE;
                    end else begin
                        if (p_reg == CODE_RIGHT) begin
                            col_nxt  = col - 1'b1;
                            addr_nxt = cur_addr - 1'b1;
                        end else begin
                            row_nxt  = row - 1'b1;
                            addr_nxt = cur_addr - ROW_STEP;
                        end
                        p_en_nxt   = 1'b1;
                        p_addr_nxt = addr_nxt;
                        state_nxt  = RD_P;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            cur_addr <= '0;
            len      <= '0;
            cost     <= '0;
            err      <= 1'b0;
            p_reg    <= '0;
            p_addr   <= '0;
            l_addr   <= '0;
            q_addr   <= '0;
            q_out    <= '0;
            p_en     <= 1'b0;
            l_en     <= 1'b0;
            q_en     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            cur_addr <= addr_nxt;
            len      <= len_nxt;
            cost     <= cost_nxt;
            err      <= err_nxt;
            p_reg    <= p_reg_nxt;
            p_addr   <= p_addr_nxt;
            l_addr   <= l_addr_nxt;
            q_addr   <= q_addr_nxt;
            q_out    <= q_out_nxt;
            p_en     <= p_en_nxt;
            l_en     <= l_en_nxt;
            q_en     <= q_en_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
        end
    end

    assign bus.p_addr = p_addr;
    assign bus.l_addr = l_addr;
    assign bus.q_addr = q_addr;
    assign bus.p_en   = p_en;
    assign bus.p_rw   = 1'b0;
    assign bus.l_en   = l_en;
    assign bus.l_rw   = 1'b0;
    assign bus.q_en   = q_en;
    assign bus.q_rw   = q_en;
    assign bus.q_out  = q_out;
    assign bus.cost   = cost;
    assign bus.len    = len;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
endmodule
